// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared constants and types for the framebuffer scanout arbiter.
// Geometry, pixel/address widths and the fetch FSM state encoding.
package fb_scanout_arbiter_pkg;

   localparam int VGA_WIDTH       = 640;
   localparam int VGA_HEIGHT      = 480;
   localparam int VGA_COLOR_DEPTH = 4;
   localparam int PIX_W           = 3 * VGA_COLOR_DEPTH;
   localparam int ADDR_W          = 19;
   localparam int WR_SLOT_PERIOD  = 8;
   localparam int LINE_W          = 10;
   localparam int FB_PIXELS       = VGA_WIDTH * VGA_HEIGHT;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = 800;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = 525;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fb_state_t;

   function automatic logic [ADDR_W-1:0] line_base(
      input logic [LINE_W-1:0] y
   );
      return ADDR_W'(y) * ADDR_W'(VGA_WIDTH);
   endfunction

endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// Pixel writer handshake, framebuffer SRAM port and line-buffer write port.
// The arbiter is the slave side; the surrounding system is the master side.
interface fb_scanout_arbiter_if;
   import fb_scanout_arbiter_pkg::*;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;

   logic              lb_we;
   logic              lb_bank;
   logic [LINE_W-1:0] lb_addr;
   logic [PIX_W-1:0]  lb_data;

   modport master (
      output wr_valid, wr_addr, wr_data, mem_rdata,
      input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  lb_we, lb_bank, lb_addr, lb_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, mem_rdata,
      output wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output lb_we, lb_bank, lb_addr, lb_data
   );

endinterface

// File: rtl/fb_scanout_arbiter_slot_timer.sv
// Modulo-N cycle counter; wrap is high in the last count of each period.
// Clear has priority over counting.
module fb_scanout_arbiter_slot_timer #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic wrap
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   logic [CW-1:0] cnt;

   assign wrap = (cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer SRAM arbiter: fetches display lines into a ping-pong line
// buffer, serving the pixel writer in idle cycles and periodic fetch slots.
module fb_scanout_arbiter
   import fb_scanout_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              line_req,
   input  logic [LINE_W-1:0] line_y,
   output logic              busy,
   output logic              line_done,
   output logic              fetch_overrun,
   fb_scanout_arbiter_if.slave bus
);

   fb_state_t         state;
   logic [ADDR_W-1:0] base;
   logic [LINE_W-1:0] pix_cnt;
   logic              bank;

   logic slot_open;
   logic req_ok;
   logic fetch_start;
   logic abort;
   logic wr_fire;
   logic wr_hit;
   logic rd_issue;
   logic rd_last;

   assign busy        = (state != IDLE);
   assign req_ok      = (line_y < LINE_W'(VGA_HEIGHT));
   assign fetch_start = !rst && line_req && req_ok;
   assign abort       = line_req && busy && !req_ok;

   fb_scanout_arbiter_slot_timer #(
      .N (WR_SLOT_PERIOD)
   ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .clr  (fetch_start),
      .en   (state == FETCH),
      .wrap (slot_open)
   );

   always_comb begin
      bus.wr_ready = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE:    bus.wr_ready = !line_req;
            FETCH:   bus.wr_ready = slot_open;
            DRAIN:   bus.wr_ready = 1'b1;
            default: bus.wr_ready = 1'b0;
         endcase
      end
   end

   // Out-of-range writes complete the handshake but never reach the SRAM.
   assign wr_fire  = bus.wr_valid && bus.wr_ready;
   assign wr_hit   = wr_fire && (bus.wr_addr < ADDR_W'(FB_PIXELS));
   assign rd_issue = !rst && (state == FETCH) && !wr_fire && !line_req;
   assign rd_last  = (pix_cnt == LINE_W'(VGA_WIDTH - 1));

   assign bus.mem_en    = wr_hit || rd_issue;
   assign bus.mem_we    = wr_fire;
   assign bus.mem_addr  = wr_fire ? bus.wr_addr : base + ADDR_W'(pix_cnt);
   assign bus.mem_wdata = bus.wr_data;

   // SRAM read data arrives in the cycle lb_we is high, so it passes straight through.
   assign bus.lb_data = bus.lb_we ? bus.mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         base          <= '0;
         pix_cnt       <= '0;
         bank          <= 1'b0;
         fetch_overrun <= 1'b0;
         line_done     <= 1'b0;
         bus.lb_we     <= 1'b0;
         bus.lb_addr   <= '0;
         bus.lb_bank   <= 1'b0;
      end else begin
         bus.lb_we <= rd_issue;
         line_done <= rd_issue && rd_last;
         if (rd_issue) begin
            bus.lb_addr <= pix_cnt;
            bus.lb_bank <= bank;
         end
         if (line_req && busy) begin
            fetch_overrun <= 1'b1;
         end
         unique case (1'b1)
            fetch_start: begin
               state   <= FETCH;
               base    <= line_base(line_y);
               pix_cnt <= '0;
               bank    <= line_y[0];
            end
            abort: begin
               state <= IDLE;
            end
            rd_issue: begin
               pix_cnt <= pix_cnt + LINE_W'(1);
               if (rd_last) begin
                  state <= DRAIN;
               end
            end
            (state == DRAIN) && !line_req: begin
               state <= IDLE;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter: a table of writer vectors in IDLE
// plus hand-written fetch, contention, overrun and reset sequences.
module tb_fb_scanout_arbiter;
   import fb_scanout_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       line_req;
   logic [9:0] line_y;
   logic       busy;
   logic       line_done;
   logic       fetch_overrun;

   int errors = 0;
   int checks = 0;
   int nrd, nlb, nwr, ndone, bad, first_lb, last_lb, done_k;
   int cnt_en, cnt_busy, cnt_done;

   typedef struct {
      logic v;
      logic req;
      int   addr;
      int   data;
      logic rdy;
      logic en;
   } wvec_t;

   wvec_t tv[6];

   fb_scanout_arbiter_if bus ();

   fb_scanout_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .line_req      (line_req),
      .line_y        (line_y),
      .busy          (busy),
      .line_done     (line_done),
      .fetch_overrun (fetch_overrun),
      .bus           (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [PIX_W-1:0] pat(input int a);
      return PIX_W'((a * 7 + 3) % 4096);
   endfunction

   // SRAM model: read data valid one cycle after the read.
   always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we) begin
         bus.mem_rdata <= pat(int'(bus.mem_addr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic req(input int y);
      line_y   = 10'(y);
      line_req = 1'b1;
      step();
      line_req = 1'b0;
      #1;
   endtask

   // Observe one fetch starting at its first FETCH cycle (k=1).
   task automatic run_line(input int base, input logic bank, input int max_k);
      nrd = 0; nlb = 0; nwr = 0; ndone = 0; bad = 0;
      first_lb = 0; last_lb = 0; done_k = 0;
      for (int k = 1; k <= max_k; k++) begin
         if (!busy) break;
         if (bus.mem_en && !bus.mem_we) begin
            if (bus.mem_addr != ADDR_W'(base + nrd)) bad++;
            nrd++;
         end
         if (bus.wr_valid && bus.wr_ready) begin
            nwr++;
            if (nrd < VGA_WIDTH && ((k - 1) % WR_SLOT_PERIOD) != WR_SLOT_PERIOD - 1) bad++;
            if (bus.mem_addr != bus.wr_addr) bad++;
         end
         if (bus.lb_we) begin
            if (bus.lb_addr != 10'(nlb)) bad++;
            if (bus.lb_data != pat(base + nlb)) bad++;
            if (bus.lb_bank != bank) bad++;
            if (nlb == 0) first_lb = k;
            last_lb = k;
            nlb++;
         end
         if (line_done) begin
            ndone++;
            done_k = k;
         end
         step();
      end
   endtask

   initial begin
      rst          = 1'b1;
      line_req     = 1'b0;
      line_y       = '0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;

      tv[0] = '{1'b1, 1'b0, 1234,   'hABC, 1'b1, 1'b1};
      tv[1] = '{1'b1, 1'b0, 307200, 'h111, 1'b1, 1'b0};
      tv[2] = '{1'b1, 1'b0, 307199, 'hFFF, 1'b1, 1'b1};
      tv[3] = '{1'b0, 1'b0, 5,      'h222, 1'b1, 1'b0};
      tv[4] = '{1'b1, 1'b0, 524287, 'h333, 1'b1, 1'b0};
      tv[5] = '{1'b1, 1'b1, 77,     'h444, 1'b0, 1'b0};

      // Reset state, writer requesting throughout.
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_lb_we", bus.lb_we, 0);
      chk("rst_lb_addr", bus.lb_addr, 0);
      chk("rst_lb_data", bus.lb_data, 0);
      chk("rst_lb_bank", bus.lb_bank, 0);
      chk("rst_done", line_done, 0);
      chk("rst_overrun", fetch_overrun, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      rst = 1'b0;
      bus.wr_valid = 1'b0;
      step();

      // Writer vectors in IDLE; the last one carries an out-of-range line_req.
      line_y = 10'd480;
      for (int i = 0; i < 6; i++) begin
         bus.wr_valid = tv[i].v;
         bus.wr_addr  = ADDR_W'(tv[i].addr);
         bus.wr_data  = PIX_W'(tv[i].data);
         line_req     = tv[i].req;
         #1;
         chk($sformatf("vec%0d_ready", i), bus.wr_ready, tv[i].rdy);
         chk($sformatf("vec%0d_en", i), bus.mem_en, tv[i].en);
         if (tv[i].v && tv[i].rdy) begin
            chk($sformatf("vec%0d_we", i), bus.mem_we, 1);
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, tv[i].addr);
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, tv[i].data);
         end
         step();
         line_req = 1'b0;
      end
      bus.wr_valid = 1'b0;
      #1;

      // Invalid line in IDLE: nothing happens.
      req(480);
      cnt_en = 0; cnt_busy = 0; cnt_done = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.mem_en) cnt_en++;
         if (busy) cnt_busy++;
         if (line_done) cnt_done++;
         step();
      end
      chk("inv_mem_en", cnt_en, 0);
      chk("inv_busy", cnt_busy, 0);
      chk("inv_done", cnt_done, 0);
      chk("inv_overrun", fetch_overrun, 0);

      // Uncontended fetch of line 0.
      line_y = 10'd0;
      line_req = 1'b1;
      #1;
      chk("req_cycle_ready", bus.wr_ready, 0);
      step();
      line_req = 1'b0;
      #1;
      run_line(0, 1'b0, 900);
      chk("l0_reads", nrd, 640);
      chk("l0_lbwrites", nlb, 640);
      chk("l0_first_lb", first_lb, 2);
      chk("l0_last_lb", last_lb, 641);
      chk("l0_done_k", done_k, 641);
      chk("l0_ndone", ndone, 1);
      chk("l0_bad", bad, 0);
      chk("l0_idle", busy, 0);

      // Fetch of line 5 with the writer always requesting.
      bus.wr_valid = 1'b1;
      bus.wr_addr  = ADDR_W'(100);
      bus.wr_data  = PIX_W'('h123);
      req(5);
      run_line(3200, 1'b1, 900);
      bus.wr_valid = 1'b0;
      chk("l5_reads", nrd, 640);
      chk("l5_last_lb", last_lb, 732);
      chk("l5_done_k", done_k, 732);
      chk("l5_writes", nwr, 92);
      chk("l5_bad", bad, 0);
      chk("l5_idle", busy, 0);
      step();

      // Last line reaches the top framebuffer address.
      req(479);
      run_line(306560, 1'b1, 900);
      chk("l479_reads", nrd, 640);
      chk("l479_ndone", ndone, 1);
      chk("l479_bad", bad, 0);
      step();

      // Invalid line during FETCH aborts to IDLE and flags overrun.
      req(1);
      run_line(640, 1'b1, 20);
      chk("abort_pre_overrun", fetch_overrun, 0);
      line_y   = 10'd480;
      line_req = 1'b1;
      step();
      line_req = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_overrun", fetch_overrun, 1);
      step();

      // Reset in the middle of a fetch.
      req(3);
      run_line(1920, 1'b1, 50);
      bus.wr_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("mrst_wr_ready", bus.wr_ready, 0);
      chk("mrst_mem_en", bus.mem_en, 0);
      step();
      chk("mrst_busy", busy, 0);
      chk("mrst_lb_we", bus.lb_we, 0);
      chk("mrst_overrun", fetch_overrun, 0);
      chk("mrst_wr_ready2", bus.wr_ready, 0);
      rst = 1'b0;
      #1;
      chk("mrst_idle_ready", bus.wr_ready, 1);
      bus.wr_valid = 1'b0;
      step();

      // Second line_req 100 cycles into a fetch restarts on the new line.
      req(10);
      run_line(6400, 1'b0, 100);
      chk("ovr_pre_reads", nrd, 100);
      chk("ovr_pre_done", ndone, 0);
      chk("ovr_pre_bad", bad, 0);
      line_y   = 10'd11;
      line_req = 1'b1;
      #1;
      chk("ovr_inflight_we", bus.lb_we, 1);
      chk("ovr_inflight_addr", bus.lb_addr, 99);
      chk("ovr_inflight_bank", bus.lb_bank, 0);
      chk("ovr_inflight_data", bus.lb_data, pat(6499));
      step();
      line_req = 1'b0;
      #1;
      chk("ovr_flag", fetch_overrun, 1);
      run_line(7040, 1'b1, 900);
      chk("ovr_reads", nrd, 640);
      chk("ovr_lbwrites", nlb, 640);
      chk("ovr_ndone", ndone, 1);
      chk("ovr_bad", bad, 0);
      chk("ovr_sticky", fetch_overrun, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
